n64_poll_scheduler: RTL and testbench

Sequencer between the N64 APB register block and the N64 serial interface. It issues periodic controller polls at a programmed cycle interval and supervises each transaction with a timeout. It latches the returned button word, tracks consecutive failures, and auto-issues a controller reset when the link is judged down. It replaces direct level control of `polling_enable`/`controller_reset` by software.

---
 rtl/n64_poll_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_n64_poll_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_poll_scheduler.sv
// Sequences periodic N64 controller polls with a per-transaction timeout, latches the
// button word, counts failures and auto-issues a controller reset when the link is down.
module n64_poll_scheduler #(
    parameter int PERIOD_W       = 24,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int MAX_FAILS      = 3,
    parameter int RESET_CYCLES   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    input  logic                poll_now,
    input  logic                reset_req,
    input  logic                poll_done,
    input  logic                poll_fail,
    input  logic [31:0]         button_data_in,
    output logic                poll_start,
    output logic                controller_reset,
    output logic [31:0]         button_data,
    output logic                data_valid,
    output logic                new_data,
    output logic                busy,
    output logic                link_down,
    output logic [7:0]          fail_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam logic [TW-1:0]       T_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]       T_ONE      = TW'(1);
    localparam logic [RW-1:0]       R_LAST     = RW'(RESET_CYCLES - 1);
    localparam logic [RW-1:0]       R_ONE      = RW'(1);
    localparam logic [PERIOD_W-1:0] P_ONE      = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] P_MAX      = '1;
    localparam logic [7:0]          FAIL_LIMIT = 8'(MAX_FAILS);

    typedef enum logic [1:0] {IDLE, POLL, WAIT, CRESET} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [RW-1:0]       rcnt_q, rcnt_d;
    logic [7:0]          consec_q, consec_d;
    logic [7:0]          fail_count_q, fail_count_d;
    logic [31:0]         button_data_q, button_data_d;
    logic                data_valid_q, data_valid_d;
    logic                new_data_q, new_data_d;
    logic                link_down_q, link_down_d;
    logic                poll_start_q, poll_start_d;
    logic                controller_reset_q, controller_reset_d;
    logic                busy_q, busy_d;
    logic                pend_rst_q, pend_rst_d;
    logic                pend_poll_q, pend_poll_d;
    logic                fail_hit;
    logic                period_due;

    always_comb begin
        state_d       = state_q;
        pcnt_d        = (pcnt_q == P_MAX) ? pcnt_q : pcnt_q + P_ONE;
        tcnt_d        = (state_q == POLL) ? tcnt_q + T_ONE : tcnt_q;
        rcnt_d        = (state_q == CRESET) ? rcnt_q + R_ONE : rcnt_q;
        consec_d      = consec_q;
        fail_count_d  = fail_count_q;
        button_data_d = button_data_q;
        data_valid_d  = data_valid_q;
        link_down_d   = link_down_q;
        new_data_d    = 1'b0;
        // Requests that arrive while a sequence is in flight are remembered one-deep.
        pend_rst_d    = pend_rst_q  | (reset_req & (state_q != IDLE));
        pend_poll_d   = pend_poll_q | (poll_now  & (state_q != IDLE));
        fail_hit      = poll_fail | (tcnt_q == T_LAST);
        period_due    = run && (period != '0) && (pcnt_q >= period - P_ONE);

        case (state_q)
            IDLE: begin
                if (reset_req || pend_rst_q) begin
                    state_d = CRESET;
                end else if (poll_now || pend_poll_q || (run && (period != '0))) begin
                    state_d = POLL;
                end
            end
            POLL: begin
                if (fail_hit) begin
                    fail_count_d = (fail_count_q == 8'hFF) ? fail_count_q : fail_count_q + 8'd1;
                    if (consec_q + 8'd1 >= FAIL_LIMIT) begin
                        link_down_d  = 1'b1;
                        data_valid_d = 1'b0;
                        consec_d     = 8'd0;
                        state_d      = CRESET;
                    end else begin
                        consec_d = consec_q + 8'd1;
                        state_d  = WAIT;
                    end
                end else if (poll_done) begin
                    button_data_d = button_data_in;
                    new_data_d    = 1'b1;
                    data_valid_d  = 1'b1;
                    consec_d      = 8'd0;
                    link_down_d   = 1'b0;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (pend_rst_q) begin
                    state_d = CRESET;
                end else if (!run && !pend_poll_q) begin
                    state_d = IDLE;
                end else if (pend_poll_q || period_due) begin
                    state_d = POLL;
                end else if (run && (period == '0)) begin
                    state_d = IDLE;
                end
            end
            CRESET: begin
                if (rcnt_q == R_LAST) begin
                    state_d = WAIT;
                    pcnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == POLL) && (state_q != POLL)) begin
            pcnt_d      = '0;
            tcnt_d      = '0;
            pend_poll_d = 1'b0;
        end
        if ((state_d == CRESET) && (state_q != CRESET)) begin
            rcnt_d       = '0;
            data_valid_d = 1'b0;
            pend_rst_d   = 1'b0;
        end

        poll_start_d       = (state_d == POLL) && (state_q != POLL);
        controller_reset_d = (state_d == CRESET);
        busy_d             = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            pcnt_q             <= '0;
            tcnt_q             <= '0;
            rcnt_q             <= '0;
            consec_q           <= 8'd0;
            fail_count_q       <= 8'd0;
            button_data_q      <= 32'd0;
            data_valid_q       <= 1'b0;
            new_data_q         <= 1'b0;
            link_down_q        <= 1'b0;
            poll_start_q       <= 1'b0;
            controller_reset_q <= 1'b0;
            busy_q             <= 1'b0;
            pend_rst_q         <= 1'b0;
            pend_poll_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            pcnt_q             <= pcnt_d;
            tcnt_q             <= tcnt_d;
            rcnt_q             <= rcnt_d;
            consec_q           <= consec_d;
            fail_count_q       <= fail_count_d;
            button_data_q      <= button_data_d;
            data_valid_q       <= data_valid_d;
            new_data_q         <= new_data_d;
            link_down_q        <= link_down_d;
            poll_start_q       <= poll_start_d;
            controller_reset_q <= controller_reset_d;
            busy_q             <= busy_d;
            pend_rst_q         <= pend_rst_d;
            pend_poll_q        <= pend_poll_d;
        end
    end

    assign poll_start       = poll_start_q;
    assign controller_reset = controller_reset_q;
    assign button_data      = button_data_q;
    assign data_valid       = data_valid_q;
    assign new_data         = new_data_q;
    assign busy             = busy_q;
    assign link_down        = link_down_q;
    assign fail_count       = fail_count_q;

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Bench for n64_poll_scheduler: serial-side responder, button-word scoreboard,
// table of manual polls and hand-written timing sequences.
module tb_n64_poll_scheduler;

    localparam logic [1:0] M_NONE = 2'd0, M_DONE = 2'd1, M_FAIL = 2'd2, M_BOTH = 2'd3;

    logic        clk = 1'b0;
    logic        reset, run, poll_now, reset_req, poll_done, poll_fail;
    logic [23:0] period;
    logic [31:0] button_data_in, button_data;
    logic        poll_start, controller_reset, data_valid, new_data, busy, link_down;
    logic [7:0]  fail_count;

    int          cyc = 0;
    int          checks = 0, passes = 0;
    logic [1:0]  resp_mode = M_NONE;
    int          resp_delay = 3;
    logic [31:0] next_word = 32'd1;
    int          nd_cnt = 0;
    int          starts[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] word;
        logic [31:0] exp_bd;
        logic [7:0]  exp_fc;
        logic        exp_dv;
        logic        exp_ld;
    } vec_t;
    vec_t tbl[8];

    n64_poll_scheduler #(.PERIOD_W(24), .TIMEOUT_CYCLES(50), .MAX_FAILS(3), .RESET_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .run(run), .period(period), .poll_now(poll_now),
        .reset_req(reset_req), .poll_done(poll_done), .poll_fail(poll_fail),
        .button_data_in(button_data_in), .poll_start(poll_start),
        .controller_reset(controller_reset), .button_data(button_data),
        .data_valid(data_valid), .new_data(new_data), .busy(busy),
        .link_down(link_down), .fail_count(fail_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_starts(input int n, input int limit, input string name);
        int k = 0;
        while (starts.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(starts.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        tick(2);
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic pulse_now();
        poll_now = 1'b1;
        tick(1);
        poll_now = 1'b0;
    endtask

    // Serial-side model: answers each poll_start according to resp_mode after resp_delay cycles.
    initial begin
        logic [1:0] mode;
        poll_done = 1'b0;
        poll_fail = 1'b0;
        button_data_in = 32'd0;
        forever begin
            @(negedge clk);
            if (poll_start && !reset && resp_mode != M_NONE) begin
                mode = resp_mode;
                tick(resp_delay);
                button_data_in = next_word;
                poll_done = (mode == M_DONE) || (mode == M_BOTH);
                poll_fail = (mode == M_FAIL) || (mode == M_BOTH);
                if (mode == M_DONE) exp_q.push_back(next_word);
                next_word = next_word + 32'd1;
                tick(1);
                poll_done = 1'b0;
                poll_fail = 1'b0;
            end
        end
    end

    // Output monitor: records poll starts and scores every new_data pulse.
    initial begin
        logic [31:0] exp_w;
        forever begin
            @(negedge clk);
            if (!reset && poll_start) starts.push_back(cyc);
            if (!reset && new_data) begin
                nd_cnt++;
                check("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check("sb_button_data", button_data, exp_w);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s, k, nd0;
        tbl[0] = '{M_DONE, 32'hA5A5_0001, 32'hA5A5_0001, 8'd0, 1'b1, 1'b0};
        tbl[1] = '{M_BOTH, 32'h1234_5678, 32'hA5A5_0001, 8'd1, 1'b1, 1'b0};
        tbl[2] = '{M_FAIL, 32'h0000_0000, 32'hA5A5_0001, 8'd2, 1'b1, 1'b0};
        tbl[3] = '{M_DONE, 32'h0000_00FF, 32'h0000_00FF, 8'd2, 1'b1, 1'b0};
        tbl[4] = '{M_FAIL, 32'h0000_0000, 32'h0000_00FF, 8'd3, 1'b1, 1'b0};
        tbl[5] = '{M_FAIL, 32'h0000_0000, 32'h0000_00FF, 8'd4, 1'b1, 1'b0};
        tbl[6] = '{M_BOTH, 32'hDEAD_BEEF, 32'h0000_00FF, 8'd5, 1'b0, 1'b1};
        tbl[7] = '{M_DONE, 32'h0BAD_F00D, 32'h0BAD_F00D, 8'd5, 1'b1, 1'b0};

        reset = 1'b1; run = 1'b0; period = 24'd0; poll_now = 1'b0; reset_req = 1'b0;
        tick(3);
        check("rst_poll_start", 32'(poll_start), 32'd0);
        check("rst_controller_reset", 32'(controller_reset), 32'd0);
        check("rst_button_data", button_data, 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_new_data", 32'(new_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_link_down", 32'(link_down), 32'd0);
        check("rst_fail_count", 32'(fail_count), 32'd0);
        reset = 1'b0;
        tick(2);

        // Periodic polling, done taken 40 cycles after each start.
        starts.delete();
        nd0 = nd_cnt;
        resp_mode = M_DONE; resp_delay = 39; next_word = 32'd1; period = 24'd100;
        run = 1'b1; t0 = cyc;
        wait_starts(3, 400, "per_three_starts");
        run = 1'b0;
        check("per_first_start", 32'(starts[0]), 32'(t0 + 1));
        check("per_spacing_1", 32'(starts[1] - starts[0]), 32'd100);
        check("per_spacing_2", 32'(starts[2] - starts[1]), 32'd100);
        wait_idle("per_idle");
        check("per_new_data_pulses", 32'(nd_cnt - nd0), 32'd3);
        check("per_last_word", button_data, 32'd3);

        // Slow response, done taken 25 cycles after start with period 10.
        starts.delete();
        resp_delay = 24; period = 24'd10; run = 1'b1;
        wait_starts(3, 200, "slow_three_starts");
        run = 1'b0;
        check("slow_spacing_1", 32'(starts[1] - starts[0]), 32'd26);
        check("slow_spacing_2", 32'(starts[2] - starts[1]), 32'd26);
        wait_idle("slow_idle");

        // Table of manual polls from a clean reset.
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);
        period = 24'd0; resp_delay = 3;
        for (int i = 0; i < 8; i++) begin
            resp_mode = tbl[i].kind;
            next_word = tbl[i].word;
            pulse_now();
            wait_idle($sformatf("tbl%0d_idle", i));
            check($sformatf("tbl%0d_button_data", i), button_data, tbl[i].exp_bd);
            check($sformatf("tbl%0d_fail_count", i), 32'(fail_count), 32'(tbl[i].exp_fc));
            check($sformatf("tbl%0d_data_valid", i), 32'(data_valid), 32'(tbl[i].exp_dv));
            check($sformatf("tbl%0d_link_down", i), 32'(link_down), 32'(tbl[i].exp_ld));
        end

        // Timeouts: three silent polls take the link down, then a good answer restores it.
        starts.delete();
        resp_mode = M_NONE; period = 24'd10; run = 1'b1;
        wait_starts(1, 10, "to_first_start");
        s = starts[0];
        wait_cyc(s + 49);
        check("to_fc_before_first", 32'(fail_count), 32'd5);
        wait_cyc(s + 50);
        check("to_fc_first", 32'(fail_count), 32'd6);
        wait_cyc(s + 101);
        check("to_fc_second", 32'(fail_count), 32'd7);
        check("to_dv_second", 32'(data_valid), 32'd1);
        wait_cyc(s + 152);
        check("to_fc_third", 32'(fail_count), 32'd8);
        check("to_link_down", 32'(link_down), 32'd1);
        check("to_dv_cleared", 32'(data_valid), 32'd0);
        check("to_creset_on", 32'(controller_reset), 32'd1);
        k = 0;
        while (controller_reset && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("to_creset_len", 32'(k), 32'd16);
        resp_mode = M_DONE; next_word = 32'h0000_0C0C;
        check("to_second_start", 32'(starts[1]), 32'(s + 51));
        check("to_third_start", 32'(starts[2]), 32'(s + 102));
        wait_starts(4, 40, "to_resume_start");
        check("to_resume_cycle", 32'(starts[3]), 32'(s + 178));
        wait_cyc(s + 182);
        check("to_link_restored", 32'(link_down), 32'd0);
        check("to_dv_restored", 32'(data_valid), 32'd1);
        run = 1'b0;
        wait_idle("to_idle");

        // Pending reset and poll raised mid-POLL.
        starts.delete();
        resp_mode = M_DONE; resp_delay = 10; period = 24'd0;
        pulse_now();
        wait_starts(1, 10, "pend_first_start");
        s = starts[0];
        wait_cyc(s + 2);
        reset_req = 1'b1; poll_now = 1'b1;
        tick(1);
        reset_req = 1'b0; poll_now = 1'b0;
        k = 0;
        while (!controller_reset && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("pend_creset_cycle", 32'(cyc), 32'(s + 12));
        k = 0;
        while (controller_reset && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("pend_creset_len", 32'(k), 32'd16);
        wait_starts(2, 20, "pend_second_start");
        check("pend_second_cycle", 32'(starts[1]), 32'(s + 29));
        wait_idle("pend_idle");
        tick(20);
        check("pend_total_starts", 32'(starts.size()), 32'd2);

        // Synchronous reset on cycle 5 of a controller reset.
        reset_req = 1'b1;
        tick(1);
        reset_req = 1'b0;
        check("rcr_creset_started", 32'(controller_reset), 32'd1);
        tick(4);
        check("rcr_creset_cycle5", 32'(controller_reset), 32'd1);
        reset = 1'b1;
        tick(1);
        check("rcr_controller_reset", 32'(controller_reset), 32'd0);
        check("rcr_poll_start", 32'(poll_start), 32'd0);
        check("rcr_busy", 32'(busy), 32'd0);
        check("rcr_fail_count", 32'(fail_count), 32'd0);
        check("rcr_button_data", button_data, 32'd0);
        check("rcr_data_valid", 32'(data_valid), 32'd0);
        check("rcr_link_down", 32'(link_down), 32'd0);
        reset = 1'b0;
        tick(5);
        check("rcr_stays_idle", 32'(busy), 32'd0);
        check("rcr_no_creset", 32'(controller_reset), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
